ones_pattern_gen: RTL and testbench

//   Inverse of the ones counter: given a ones-count k, emits every WIDTH-bit word whose popcount is k.

---
 rtl/ones_gen_pkg.sv | 31 +++
 rtl/ones_pattern_gen_next_comb.sv | 27 ++
 rtl/ones_pattern_gen.sv | 95 +++++++++
 tb/tb_ones_pattern_gen.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ones_gen_pkg.sv
// Shared state encoding and pattern helpers for the k-of-WIDTH word enumerator.
package ones_gen_pkg;

  localparam int unsigned MAX_W = 64;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [MAX_W-1:0] first_pat(input int unsigned k);
    logic [MAX_W-1:0] p;
    p = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < k) p[i] = 1'b1;
    end
    return p;
  endfunction

  // k ones packed against the top of a w-bit word
  function automatic logic [MAX_W-1:0] last_pat(input int unsigned k, input int unsigned w);
    return first_pat(k) << (w - k);
  endfunction

  function automatic int unsigned ctz(input logic [MAX_W-1:0] x);
    int unsigned r;
    r = MAX_W;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (x[i] && (r == MAX_W)) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/ones_pattern_gen_next_comb.sv
// Combinational Gosper successor: next larger WIDTH-bit word with the same popcount.
module next_comb
  import ones_gen_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] x_i,
  output logic [WIDTH-1:0] next_o
);

  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] nt;
  logic [WIDTH-1:0] low;
  logic [MAX_W-1:0] x_ext;
  int unsigned      sh;

  always_comb begin
    x_ext            = '0;
    x_ext[WIDTH-1:0] = x_i;
    t      = x_i | (x_i - WIDTH'(1));
    nt     = ~t;
    low    = nt & (~nt + WIDTH'(1));
    sh     = ctz(x_ext) + 1;
    next_o = (t + WIDTH'(1)) | ((low - WIDTH'(1)) >> sh);
  end

endmodule

// File: rtl/ones_pattern_gen.sv
// Streams every WIDTH-bit word with popcount k in ascending order over valid/ready.
module ones_pattern_gen
  import ones_gen_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH + 1),
  parameter int unsigned NW    = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CW-1:0]    k,
  output logic             busy,
  output logic             pat_valid,
  input  logic             pat_ready,
  output logic [WIDTH-1:0] pat,
  output logic             pat_last,
  output logic [NW-1:0]    beat_cnt,
  output logic             done,
  output logic             err
);

  state_t           state_q, state_d;
  logic [CW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [NW-1:0]    beat_q, beat_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] succ;
  logic             at_last;

  next_comb #(.WIDTH(WIDTH)) u_next (
    .x_i    (pat_q),
    .next_o (succ)
  );

  // Gated by RUN so the reset pattern (0 with k_q=0) is not reported as last
  assign at_last = (state_q == RUN) &&
                   (MAX_W'(pat_q) == last_pat(32'(k_q), WIDTH));

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    pat_d   = pat_q;
    beat_d  = beat_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (32'(k) > WIDTH) begin
            err_d = 1'b1;
          end else begin
            k_d     = k;
            pat_d   = WIDTH'(first_pat(32'(k)));
            beat_d  = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (pat_ready) begin
          beat_d = beat_q + NW'(1);
          if (at_last) state_d = DONE;
          else         pat_d   = succ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      pat_q   <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      pat_q   <= pat_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign pat_valid = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign pat       = pat_q;
  assign pat_last  = at_last;
  assign beat_cnt  = beat_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Scoreboard bench for ones_pattern_gen: expected words queued at start, checked by a monitor.
module tb_ones_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n, start, pat_ready;
  logic [3:0] k;
  logic       busy, pat_valid, pat_last, done, err;
  logic [7:0] pat;
  logic [7:0] beat_cnt;

  typedef struct {
    logic [7:0]  pat;
    logic        last;
    int unsigned beat;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] obs_q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         cur_k = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_pat, prev_beat;

  ones_pattern_gen #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k(k), .busy(busy),
    .pat_valid(pat_valid), .pat_ready(pat_ready), .pat(pat), .pat_last(pat_last),
    .beat_cnt(beat_cnt), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference enumeration by exhaustive ascending scan, independent of the successor logic
  task automatic push_seq(input int kk);
    logic [7:0] ws[$];
    logic [7:0] wv;
    exp_t e;
    for (int w = 0; w < 256; w++) begin
      wv = w[7:0];
      if ($countones(wv) == kk) ws.push_back(wv);
    end
    for (int i = 0; i < ws.size(); i++) begin
      e.pat  = ws[i];
      e.last = (i == ws.size() - 1);
      e.beat = i;
      exp_q.push_back(e);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prev_stall) begin
          chk("stall_valid", pat_valid, 1);
          chk("stall_pat", pat, prev_pat);
          chk("stall_beat", beat_cnt, prev_beat);
        end
        if (pat_valid && pat_ready) begin
          if (exp_q.size() == 0) begin
            chk("sb_unexpected_beat", pat, -1);
          end else begin
            e = exp_q.pop_front();
            chk("sb_pat", pat, e.pat);
            chk("sb_last", pat_last, e.last);
            chk("sb_beat", beat_cnt, e.beat);
            chk("sb_popcount", $countones(pat), cur_k);
            obs_q.push_back(pat);
          end
        end
        prev_stall = pat_valid && !pat_ready;
        prev_pat   = pat;
        prev_beat  = beat_cnt;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic do_start(input int kk);
    @(posedge clk); #1;
    start = 1'b1;
    k     = 4'(kk);
    @(posedge clk); #1;
    start = 1'b0;
    k     = 4'd5;
    @(negedge clk);
    if (kk <= 8) begin
      chk("first_valid", pat_valid, 1);
      chk("first_busy", busy, 1);
    end
  endtask

  // Poll for the done pulse within a cycle budget; optionally randomise ready meanwhile
  task automatic wait_done(input int budget, input bit rnd, input int exp_beats, input bit start_at_done);
    bit seen = 0;
    for (int c = 0; c < budget && !seen; c++) begin
      if (done) begin
        seen = 1;
      end else begin
        @(posedge clk); #1;
        if (rnd) pat_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
    end
    chk("done_seen", seen, 1);
    if (seen) begin
      chk("done_busy", busy, 1);
      chk("done_beat_cnt", beat_cnt, exp_beats);
      chk("done_no_valid", pat_valid, 0);
      if (start_at_done) begin
        start = 1'b1;
        k     = 4'd3;
      end
      pat_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("done_pulse_end", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_no_valid", pat_valid, 0);
      chk("beat_cnt_hold", beat_cnt, exp_beats);
    end
    chk("sb_drained", exp_q.size(), 0);
  endtask

  task automatic run_seq(input int kk, input int beats, input bit rnd);
    obs_q.delete();
    cur_k = kk;
    push_seq(kk);
    do_start(kk);
    wait_done(beats * 6 + 20, rnd, beats, 1'b0);
    chk("obs_count", obs_q.size(), beats);
  endtask

  initial begin : main
    rst_n = 1'b0; start = 1'b0; k = '0; pat_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", pat_valid, 0);
    chk("rst_last", pat_last, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_pat", pat, 0);
    chk("rst_beat", beat_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // k=3 full throughput
    run_seq(3, 56, 1'b0);
    if (obs_q.size() == 56) begin
      chk("k3_w0", obs_q[0], 8'h07);
      chk("k3_w1", obs_q[1], 8'h0B);
      chk("k3_w2", obs_q[2], 8'h0D);
      chk("k3_last", obs_q[55], 8'hE0);
    end

    // single-word edges
    run_seq(0, 1, 1'b0);
    if (obs_q.size() == 1) chk("k0_word", obs_q[0], 8'h00);
    run_seq(8, 1, 1'b0);
    if (obs_q.size() == 1) chk("k8_word", obs_q[0], 8'hFF);

    // out-of-range k
    cur_k = 9;
    do_start(9);
    chk("err_pulse", err, 1);
    chk("err_busy", busy, 0);
    chk("err_valid", pat_valid, 0);
    @(negedge clk);
    chk("err_one_cycle", err, 0);
    chk("err_busy2", busy, 0);

    // random back-pressure
    run_seq(2, 28, 1'b1);
    for (int i = 1; i < obs_q.size(); i++) chk("k2_ascending", obs_q[i] > obs_q[i-1], 1);

    // async reset mid-sequence, then clean restart
    obs_q.delete();
    cur_k = 4;
    push_seq(4);
    do_start(4);
    begin
      bit hit = 0;
      for (int c = 0; c < 40 && !hit; c++) begin
        if (beat_cnt == 8'd10) hit = 1;
        else @(negedge clk);
      end
      chk("k4_reach_beat10", hit, 1);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_valid", pat_valid, 0);
    chk("abort_pat", pat, 0);
    chk("abort_beat", beat_cnt, 0);
    chk("abort_last", pat_last, 0);
    chk("abort_done", done, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    chk("abort_no_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_seq(4, 70, 1'b0);
    if (obs_q.size() == 70) chk("k4_restart_first", obs_q[0], 8'h0F);

    // start during RUN and during DONE are both ignored
    obs_q.delete();
    cur_k = 1;
    push_seq(1);
    do_start(1);
    repeat (2) @(posedge clk);
    #1 start = 1'b1; k = 4'd5;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    wait_done(60, 1'b0, 8, 1'b1);
    chk("k1_count", obs_q.size(), 8);
    if (obs_q.size() == 8) begin
      chk("k1_first", obs_q[0], 8'h01);
      chk("k1_second", obs_q[1], 8'h02);
      chk("k1_last", obs_q[7], 8'h80);
    end
    repeat (3) @(negedge clk);
    chk("start_at_done_ignored", pat_valid, 0);
    chk("start_at_done_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
